// File: rtl/demux_1x8_32bit_buf_pkg.sv
// Shared parameters and helpers for the word mux/demux family.
// The slice helper extracts channel k from a packed multi-channel data bus.
package demux_1x8_32bit_buf_pkg;

   localparam int WIDTH    = 32;
   localparam int SEL_BITS = 3;
   localparam int NUM_OUT  = 1 << SEL_BITS;

   function automatic logic [WIDTH-1:0] word_slice(
      input logic [NUM_OUT*WIDTH-1:0] bus,
      input logic [SEL_BITS-1:0]      k
   );
      word_slice = bus[int'(k)*WIDTH +: WIDTH];
   endfunction

endpackage

// File: rtl/demux_1x8_32bit_buf_chan.sv
// One demux channel: a single-word holding register with its valid flag.
// A load in the same cycle as a drain replaces the word and keeps valid set.
module demux_chan_reg
   import demux_1x8_32bit_buf_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;
   logic             valid_d;
   logic             valid_q;

   // Next-state: load wins over drain; data is held after a drain.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = data;
         valid_d = 1'b1;
      end else if (drain) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Holding register and valid flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= {WIDTH{1'b0}};
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;

endmodule

// File: rtl/demux_1x8_32bit_buf.sv
// Buffered 1-to-8 word demultiplexer: routes one 32-bit stream to per-channel
// holding registers by select, with independent valid/ready per channel.
module demux_1x8_32bit_buf
   import demux_1x8_32bit_buf_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [SEL_BITS-1:0]      in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [NUM_OUT*WIDTH-1:0] out_data,
   output logic [NUM_OUT-1:0]       out_valid,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic [15:0]              xfer_count
);

   logic               acc_s;
   logic [NUM_OUT-1:0] load_s;
   logic [15:0]        xfer_count_d;
   logic [15:0]        xfer_count_q;

   // Ready mux, accept, one-hot load decode and transfer counter update.
   always_comb begin
      in_ready     = ~out_valid[in_sel] | out_ready[in_sel];
      acc_s        = in_valid & in_ready;
      load_s       = {NUM_OUT{1'b0}};
      xfer_count_d = xfer_count_q;
      if (acc_s) begin
         load_s[in_sel] = 1'b1;
         xfer_count_d   = xfer_count_q + 16'd1;
      end else begin
         xfer_count_d   = xfer_count_q;
      end
   end

   // Count of accepted words; wraps silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xfer_count_q <= 16'd0;
      end else begin
         xfer_count_q <= xfer_count_d;
      end
   end

   assign xfer_count = xfer_count_q;

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
      demux_chan_reg u_chan (
         .clk       (clk),
         .reset     (reset),
         .load      (load_s[k]),
         .drain     (out_ready[k]),
         .data      (in_data),
         .data_out  (out_data[k*WIDTH +: WIDTH]),
         .valid_out (out_valid[k])
      );
   end

endmodule

// File: tb/tb_demux_1x8_32bit_buf.sv
// Scoreboard bench for demux_1x8_32bit_buf: accepted words are queued per
// channel and a negedge monitor checks every delivered word in order.
module tb_demux_1x8_32bit_buf;
   import demux_1x8_32bit_buf_pkg::*;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [WIDTH-1:0]         in_data;
   logic [SEL_BITS-1:0]      in_sel;
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_OUT*WIDTH-1:0] out_data;
   logic [NUM_OUT-1:0]       out_valid;
   logic [NUM_OUT-1:0]       out_ready;
   logic [15:0]              xfer_count;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q [NUM_OUT][$];
   logic [15:0] exp_cnt;

   demux_1x8_32bit_buf dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: a word is delivered whenever valid and ready meet at a clock edge.
   always @(negedge clk) begin
      logic [31:0] w;
      if (!reset) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               if (exp_q[k].size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL deliver_ch%0d: got %h, expected no word", k,
                           word_slice(out_data, k[2:0]));
               end else begin
                  w = exp_q[k].pop_front();
                  chk($sformatf("deliver_ch%0d", k), word_slice(out_data, k[2:0]), w);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      for (int k = 0; k < NUM_OUT; k++) exp_q[k].delete();
      exp_cnt = 16'd0;
   endtask

   task automatic send(input logic [2:0] sel, input logic [31:0] data, input int max_wait);
      int waits = 0;
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      while (!ok && waits < max_wait) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else waits++;
      end
      if (ok) begin
         exp_q[sel].push_back(data);
         exp_cnt++;
      end else begin
         tests++;
         fails++;
         $display("FAIL send_timeout: sel %0d data %h not accepted, expected acceptance within %0d cycles",
                  sel, data, max_wait);
      end
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sel    = 3'd0;
      in_data   = 32'd0;
      out_ready = 8'h00;
      exp_cnt   = 16'd0;
      repeat (2) tick();
      chk("reset_out_valid", {24'd0, out_valid}, 32'h0);
      chk("reset_xfer_count", {16'd0, xfer_count}, 32'h0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'h1);
      reset = 1'b0;
      tick();

      // T2 routing: one word per channel, nothing drained
      for (int k = 0; k < NUM_OUT; k++) send(k[2:0], 32'hDEAD0000 + k, 4);
      chk("route_out_valid", {24'd0, out_valid}, 32'h000000FF);
      for (int k = 0; k < NUM_OUT; k++)
         chk($sformatf("route_slice%0d", k), word_slice(out_data, k[2:0]), 32'hDEAD0000 + k);
      chk("route_xfer_count", {16'd0, xfer_count}, 32'd8);

      // T1 reset between clock edges with all channels full
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", {24'd0, out_valid}, 32'h0);
      for (int k = 0; k < NUM_OUT; k++)
         chk($sformatf("midrst_slice%0d", k), word_slice(out_data, k[2:0]), 32'h0);
      chk("midrst_xfer_count", {16'd0, xfer_count}, 32'h0);
      flush();
      tick();
      reset = 1'b0;
      tick();

      // T3 backpressure on channel 3, channel 5 unaffected
      send(3'd3, 32'hAAAA0003, 4);
      in_valid = 1'b1;
      in_sel   = 3'd3;
      in_data  = 32'h12345678;
      @(negedge clk);
      chk("bp_in_ready_blocked", {31'd0, in_ready}, 32'h0);
      tick();
      chk("bp_slice3_held", word_slice(out_data, 3'd3), 32'hAAAA0003);
      chk("bp_xfer_count", {16'd0, xfer_count}, 32'd1);
      send(3'd5, 32'h12345678, 1);
      chk("bp_out_valid", {24'd0, out_valid}, 32'h00000028);
      chk("bp_slice5", word_slice(out_data, 3'd5), 32'h12345678);
      out_ready = 8'hFF;
      repeat (3) tick();
      chk("drain_out_valid", {24'd0, out_valid}, 32'h0);
      for (int k = 0; k < NUM_OUT; k++)
         chk($sformatf("drain_q%0d_empty", k), exp_q[k].size(), 32'd0);
      out_ready = 8'h00;

      // T4 pass-through on a full channel being drained
      send(3'd2, 32'h11112222, 4);
      out_ready = 8'h04;
      in_valid  = 1'b1;
      in_sel    = 3'd2;
      in_data   = 32'hCAFEF00D;
      @(negedge clk);
      chk("pt_in_ready", {31'd0, in_ready}, 32'h1);
      exp_q[2].push_back(32'hCAFEF00D);
      exp_cnt++;
      tick();
      in_valid = 1'b0;
      chk("pt_slice2", word_slice(out_data, 3'd2), 32'hCAFEF00D);
      chk("pt_out_valid2", {31'd0, out_valid[2]}, 32'h1);
      tick();
      out_ready = 8'h00;
      chk("pt_xfer_count", {16'd0, xfer_count}, 32'd4);

      // T5 throughput: 100 back-to-back words on channel 1
      out_ready = 8'h02;
      for (int i = 0; i < 100; i++) begin
         send(3'd1, 32'h50000000 + i, 1);
         chk("tp_out_valid1", {31'd0, out_valid[1]}, 32'h1);
      end
      repeat (2) tick();
      chk("tp_drained", {24'd0, out_valid}, 32'h0);
      chk("tp_q1_empty", exp_q[1].size(), 32'd0);
      out_ready = 8'h00;

      // T6 counter wrap after 65536 transfers from reset
      reset = 1'b1;
      tick();
      flush();
      reset = 1'b0;
      tick();
      out_ready = 8'hFF;
      for (int i = 0; i < 65536; i++) send(i[2:0], i, 2);
      chk("wrap_xfer_count", {16'd0, xfer_count}, 32'h0);
      chk("wrap_model_count", {16'd0, xfer_count}, {16'd0, exp_cnt});
      repeat (2) tick();
      out_ready = 8'h00;
      send(3'd6, 32'hBEEF0006, 2);
      chk("wrap_route_slice6", word_slice(out_data, 3'd6), 32'hBEEF0006);
      chk("wrap_route_valid", {24'd0, out_valid}, 32'h00000040);
      chk("wrap_route_count", {16'd0, xfer_count}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
